// File: rtl/sign_narrower.sv
// rtl/sign_narrower.sv - 32-to-16 bit two's-complement narrower behind a 2-entry FIFO with overflow counting
// Optional saturation on overflow is compiled in by defining SIGN_NARROWER_SAT_EN.

module sign_narrower #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  input  logic [31:0]      numIn,
  output logic             inReady,
  output logic             outValid,
  input  logic             outReady,
  output logic [15:0]      numOut,
  output logic             ovf,
  input  logic             ovfClear,
  output logic [CNT_W-1:0] ovfCount
);

  logic [1:0]       occ_q, occ_d;
  logic             rdy_q, rdy_d;
  logic [15:0]      head_num_q, head_num_d;
  logic             head_ovf_q, head_ovf_d;
  logic [15:0]      tail_num_q, tail_num_d;
  logic             tail_ovf_q, tail_ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        in_ovf;
  logic [15:0] in_num;
  logic        push;
  logic        pop;

  // The word fits in 16 bits only when bits 31..15 all repeat the sign.
  always_comb begin
    in_ovf = ~((&numIn[31:15]) | ~(|numIn[31:15]));
`ifdef SIGN_NARROWER_SAT_EN
    in_num = in_ovf ? (numIn[31] ? 16'h8000 : 16'h7FFF) : numIn[15:0];
`else
    in_num = numIn[15:0];
`endif
  end

  // inReady comes from a register so outReady never reaches it combinationally.
  assign push = inValid & rdy_q;
  assign pop  = outReady & (occ_q != 2'd0);

  always_comb begin
    occ_d      = occ_q;
    head_num_d = head_num_q;
    head_ovf_d = head_ovf_q;
    tail_num_d = tail_num_q;
    tail_ovf_d = tail_ovf_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_num_d = in_num;
          head_ovf_d = in_ovf;
          occ_d      = 2'd1;
        end else begin
          tail_num_d = in_num;
          tail_ovf_d = in_ovf;
          occ_d      = 2'd2;
        end
      end
      2'b01: begin
        // Head is left untouched when draining to empty, keeping outputs stable.
        if (occ_q == 2'd2) begin
          head_num_d = tail_num_q;
          head_ovf_d = tail_ovf_q;
        end
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        head_num_d = in_num;
        head_ovf_d = in_ovf;
      end
      default: ;
    endcase
    rdy_d = (occ_d != 2'd2);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ovfClear) begin
      cnt_d = (push & in_ovf) ? CNT_W'(1) : '0;
    end else if (push & in_ovf & ~(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      rdy_q      <= 1'b0;
      head_num_q <= 16'h0000;
      head_ovf_q <= 1'b0;
      tail_num_q <= 16'h0000;
      tail_ovf_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      rdy_q      <= rdy_d;
      head_num_q <= head_num_d;
      head_ovf_q <= head_ovf_d;
      tail_num_q <= tail_num_d;
      tail_ovf_q <= tail_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign inReady  = rdy_q;
  assign outValid = (occ_q != 2'd0);
  assign numOut   = head_num_q;
  assign ovf      = head_ovf_q;
  assign ovfCount = cnt_q;

endmodule

// File: tb/tb_sign_narrower.sv
// tb/tb_sign_narrower.sv - directed self-checking bench for sign_narrower

module tb_sign_narrower;

`ifdef SIGN_NARROWER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic [31:0] numIn;
  logic        inReady;
  logic        outValid;
  logic        outReady;
  logic [15:0] numOut;
  logic        ovf;
  logic        ovfClear;
  logic [1:0]  ovfCount;

  int errors = 0;
  int checks = 0;

  sign_narrower #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .numIn(numIn),
    .inReady(inReady), .outValid(outValid), .outReady(outReady),
    .numOut(numOut), .ovf(ovf), .ovfClear(ovfClear), .ovfCount(ovfCount)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inValid = 1'b0; numIn = '0; outReady = 1'b0; ovfClear = 1'b0;
    #1;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL reset_inReady got=%b exp=0", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
    checks++; if (numOut !== 16'h0000) begin errors++; $display("FAIL reset_numOut got=%h exp=0000", numOut); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (ovfCount !== 2'd0) begin errors++; $display("FAIL reset_ovfCount got=%0d exp=0", ovfCount); end
    step; step;
    rst_n = 1'b1;
    #2;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL release_before_edge_inReady got=%b exp=0", inReady); end
    step;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL release_after_edge_inReady got=%b exp=1", inReady); end
  endtask

  task automatic test_narrow;
    logic [31:0] words [8];
    logic [15:0] exp_num [8];
    logic        exp_ovf [8];
    int          cnt;
    words[0] = 32'hFFFF8000; exp_ovf[0] = 1'b0; exp_num[0] = 16'h8000;
    words[1] = 32'h00012345; exp_ovf[1] = 1'b1; exp_num[1] = SAT ? 16'h7FFF : 16'h2345;
    words[2] = 32'h80000000; exp_ovf[2] = 1'b1; exp_num[2] = SAT ? 16'h8000 : 16'h0000;
    words[3] = 32'h00007FFF; exp_ovf[3] = 1'b0; exp_num[3] = 16'h7FFF;
    words[4] = 32'hFFFF7FFF; exp_ovf[4] = 1'b1; exp_num[4] = SAT ? 16'h8000 : 16'h7FFF;
    words[5] = 32'h00008000; exp_ovf[5] = 1'b1; exp_num[5] = SAT ? 16'h7FFF : 16'h8000;
    words[6] = 32'h00000000; exp_ovf[6] = 1'b0; exp_num[6] = 16'h0000;
    words[7] = 32'hFFFFFFFF; exp_ovf[7] = 1'b0; exp_num[7] = 16'hFFFF;
    cnt = 0;
    outReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inValid = 1'b1; numIn = words[i];
      step;
      if (exp_ovf[i] && cnt < 3) cnt++;
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL narrow%0d_outValid got=%b exp=1", i, outValid); end
      checks++; if (numOut !== exp_num[i]) begin errors++; $display("FAIL narrow%0d_numOut got=%h exp=%h", i, numOut, exp_num[i]); end
      checks++; if (ovf !== exp_ovf[i]) begin errors++; $display("FAIL narrow%0d_ovf got=%b exp=%b", i, ovf, exp_ovf[i]); end
      checks++; if (ovfCount !== 2'(cnt)) begin errors++; $display("FAIL narrow%0d_ovfCount got=%0d exp=%0d", i, ovfCount, cnt); end
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL narrow%0d_inReady got=%b exp=1", i, inReady); end
    end
    inValid = 1'b0;
    step;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL narrow_drain_outValid got=%b exp=0", outValid); end
    ovfClear = 1'b1;
    step;
    ovfClear = 1'b0;
    checks++; if (ovfCount !== 2'd0) begin errors++; $display("FAIL clear_alone_ovfCount got=%0d exp=0", ovfCount); end
  endtask

  task automatic test_back_to_back;
    outReady = 1'b0;
    inValid = 1'b1; numIn = 32'h00000011;
    step;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_first_inReady got=%b exp=1", inReady); end
    numIn = 32'hFFFFFFEE;
    step;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL b2b_full_inReady got=%b exp=0", inReady); end
    checks++; if (numOut !== 16'h0011) begin errors++; $display("FAIL b2b_full_numOut got=%h exp=0011", numOut); end
    numIn = 32'h00000033;
    outReady = 1'b1;
    #2;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL b2b_full_ready_path got=%b exp=0", inReady); end
    outReady = 1'b0;
    step;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL b2b_third_inReady got=%b exp=0", inReady); end
    checks++; if (outValid !== 1'b1 || numOut !== 16'h0011) begin errors++; $display("FAIL b2b_hold got=%b/%h exp=1/0011", outValid, numOut); end
    inValid = 1'b0; outReady = 1'b1;
    step;
    checks++; if (outValid !== 1'b1 || numOut !== 16'hFFEE) begin errors++; $display("FAIL b2b_second_result got=%b/%h exp=1/ffee", outValid, numOut); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL b2b_ready_return got=%b exp=1", inReady); end
    step;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL b2b_no_third got=%b exp=0", outValid); end
    step;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL b2b_still_empty got=%b exp=0", outValid); end
  endtask

  task automatic test_saturate;
    outReady = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      inValid = 1'b1; numIn = 32'h00010000;
      step;
      checks++; if (ovfCount !== 2'((i < 3) ? i : 3)) begin errors++; $display("FAIL sat_push%0d_ovfCount got=%0d exp=%0d", i, ovfCount, (i < 3) ? i : 3); end
    end
    ovfClear = 1'b1;
    step;
    checks++; if (ovfCount !== 2'd1) begin errors++; $display("FAIL sat_clear_with_push got=%0d exp=1", ovfCount); end
    numIn = 32'h00000005;
    step;
    checks++; if (ovfCount !== 2'd0) begin errors++; $display("FAIL sat_clear_fit_push got=%0d exp=0", ovfCount); end
    ovfClear = 1'b0; inValid = 1'b0;
    step;
  endtask

  task automatic test_midreset;
    outReady = 1'b0;
    inValid = 1'b1; numIn = 32'h00010001;
    step;
    numIn = 32'hFFFE0002;
    step;
    inValid = 1'b0;
    checks++; if (outValid !== 1'b1 || ovfCount !== 2'd2) begin errors++; $display("FAIL midrst_setup got=%b/%0d exp=1/2", outValid, ovfCount); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midrst_outValid got=%b exp=0", outValid); end
    checks++; if (numOut !== 16'h0000) begin errors++; $display("FAIL midrst_numOut got=%h exp=0000", numOut); end
    checks++; if (ovfCount !== 2'd0) begin errors++; $display("FAIL midrst_ovfCount got=%0d exp=0", ovfCount); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL midrst_inReady got=%b exp=0", inReady); end
    outReady = 1'b1;
    step;
    rst_n = 1'b1;
    step;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL postrst_inReady got=%b exp=1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL postrst_stale got=%b exp=0", outValid); end
    step;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL postrst_stale2 got=%b exp=0", outValid); end
  endtask

  initial begin
    test_reset;
    test_narrow;
    test_back_to_back;
    test_saturate;
    test_midreset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sign_narrower.md
SIGN_NARROWER -- requirements
Module: sign_narrower

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the overflow event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port inValid  input  1  producer offers numIn this cycle.
REQ-005 SHALL have port numIn  input  32  two's-complement word to narrow.
REQ-006 SHALL have port inReady  output  1  block accepts numIn this cycle.
REQ-007 SHALL have port outValid  output  1  numOut/ovf hold a valid result.
REQ-008 SHALL have port outReady  input  1  consumer takes the result this cycle.
REQ-009 SHALL have port numOut  output  16  narrowed two's-complement result.
REQ-010 SHALL have port ovf  output  1  result's source did not fit in 16 bits.
REQ-011 SHALL have port ovfClear  input  1  synchronous clear of ovfCount.
REQ-012 SHALL have port ovfCount  output  CNT_W  saturating count of accepted overflowing words.

Function
REQ-013 SHALL accept a word on any cycle where inValid and inReady are both high (push).
REQ-014 SHALL deliver a result on any cycle where outValid and outReady are both high (pop).
REQ-015 SHALL buffer results in a 2-entry FIFO; inReady = registered occupancy < 2, with no combinational path from outReady to inReady.
REQ-016 SHALL present a pushed word's result on numOut/ovf with outValid high exactly one cycle after the push when the FIFO was empty.
REQ-017 SHALL, when occupancy is 1 and push and pop coincide, keep occupancy at 1 and present the new result next cycle.
REQ-018 SHALL, when occupancy is 2, refuse pushes (inReady low) even if outReady is high that cycle.
REQ-019 SHALL preserve strict arrival order; no result is dropped or duplicated under any valid/ready pattern.
REQ-020 SHALL hold numOut, ovf and outValid stable while outValid is high and outReady is low.
REQ-021 SHALL compute ovf = 1 iff numIn[31:15] are not all equal (value outside -32768..32767).
REQ-022 SHALL, when ovf = 0, set numOut = numIn[15:0], so that sign-extending numOut to 32 bits reproduces numIn.
REQ-023 SHALL increment ovfCount once per pushed word with ovf = 1, saturating at all-ones with no wrap.
REQ-024 SHALL, when ovfClear is high, load ovfCount with 0, or with 1 if an overflowing push occurs in the same cycle.
REQ-025 SHALL leave numOut and ovf unspecified-but-stable-at-last-value while outValid is low.

Reset
REQ-026 SHALL, while rst_n is low, force occupancy 0, inReady 0, outValid 0, numOut 16'h0000, ovf 0 and ovfCount 0, regardless of clk.
REQ-027 SHALL raise inReady on the first rising clk edge after rst_n deasserts.
REQ-028 SHALL discard any buffered results and in-flight pushes if reset asserts mid-operation.

Configuration
REQ-029 SHALL compile in saturation when macro SIGN_NARROWER_SAT_EN is defined: on overflow, numOut = 16'h7FFF if numIn[31] = 0, else 16'h8000.
REQ-030 SHALL, when SIGN_NARROWER_SAT_EN is not defined, set numOut = numIn[15:0] on overflow (truncation), with ovf still flagged.
REQ-031 SHALL keep ovf, ovfCount, handshake and latency identical in both configurations.

Verification
REQ-032 SHALL pass: push 32'hFFFF8000 with outReady high -> next cycle outValid = 1, numOut = 16'h8000, ovf = 0, ovfCount = 0.
REQ-033 SHALL pass: push 32'h00012345 -> ovf = 1, ovfCount = 1; numOut = 16'h7FFF with SIGN_NARROWER_SAT_EN, 16'h2345 without.
REQ-034 SHALL pass: push 32'h80000000 -> ovf = 1; numOut = 16'h8000 with SIGN_NARROWER_SAT_EN, 16'h0000 without.
REQ-035 SHALL pass: outReady low, push 3 words back-to-back -> only 2 accepted, inReady low from the third cycle; raising outReady yields both results in order, then inReady returns high.
REQ-036 SHALL pass: CNT_W = 2, push 5 overflowing words -> ovfCount = 3 (saturated); ovfClear concurrent with a 6th overflowing push -> ovfCount = 1.
REQ-037 SHALL pass: assert rst_n low between clk edges with 2 results buffered -> outValid, ovfCount and numOut go to 0 immediately; no stale result appears after reset release.
